// File: rtl/dsd_mmio_pkg.sv
// Shared definitions for the data-memory MMIO bridge: register offsets,
// timer control bit positions and timer state encoding.
package dsd_mmio_pkg;

  localparam logic [3:0] OFS_LED       = 4'd0;
  localparam logic [3:0] OFS_CYCLE     = 4'd1;
  localparam logic [3:0] OFS_TMR_LOAD  = 4'd2;
  localparam logic [3:0] OFS_TMR_COUNT = 4'd3;
  localparam logic [3:0] OFS_TMR_CTRL  = 4'd4;
  localparam logic [3:0] OFS_TMR_STAT  = 4'd5;
  localparam logic [3:0] OFS_PRESCALE  = 4'd6;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/mmio_timer.sv
// Prescaled down-counting timer with one-shot/auto-reload modes and a
// sticky EXPIRED flag (write-1-to-clear, set has priority).
module mmio_timer
  import dsd_mmio_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_load,
  input  logic                  i_wr_ctrl,
  input  logic                  i_wr_stat,
  input  logic                  i_wr_pre,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_load,
  output logic [31:0]           o_count,
  output logic [2:0]            o_ctrl,
  output logic                  o_expired,
  output logic [PRESCALE_W-1:0] o_prescale,
  output logic                  o_irq
);

  tmr_state_e            r_state;
  logic [31:0]           r_load;
  logic [31:0]           r_count;
  logic [2:0]            r_ctrl;
  logic                  r_expired;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;

  logic w_tick;
  logic w_en_rise;
  logic w_en_clear;
  logic w_expire;

  assign w_tick     = (r_state == RUN) && (r_pcnt == r_prescale);
  assign w_en_rise  = i_wr_ctrl && i_wdata[CTRL_EN] && !r_ctrl[CTRL_EN];
  assign w_en_clear = i_wr_ctrl && !i_wdata[CTRL_EN];
  // A LOAD write or an EN clear in the same cycle pre-empts the tick.
  assign w_expire   = w_tick && (r_count == 32'd0) && !i_wr_load && !w_en_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_load     <= '0;
      r_count    <= '0;
      r_ctrl     <= '0;
      r_expired  <= 1'b0;
      r_prescale <= '0;
      r_pcnt     <= '0;
    end else begin
      if (i_wr_load) r_load <= i_wdata;
      if (i_wr_pre)  r_prescale <= i_wdata[PRESCALE_W-1:0];
      if (i_wr_ctrl) r_ctrl <= i_wdata[2:0];

      if (w_expire)                   r_expired <= 1'b1;
      else if (i_wr_stat && i_wdata[0]) r_expired <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_en_rise) begin
            r_state <= RUN;
            r_count <= r_load;
            r_pcnt  <= '0;
          end
        end
        RUN: begin
          if (w_en_clear) begin
            r_state <= IDLE;
          end else if (i_wr_load) begin
            r_count <= i_wdata;
            r_pcnt  <= '0;
          end else if (w_tick) begin
            r_pcnt <= '0;
            if (r_count != 32'd0)          r_count <= r_count - 32'd1;
            else if (r_ctrl[CTRL_AUTO_RELOAD]) r_count <= r_load;
            else                           r_state <= DONE;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        DONE: begin
          if (w_en_clear) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_load     = r_load;
  assign o_count    = r_count;
  assign o_ctrl     = r_ctrl;
  assign o_expired  = r_expired;
  assign o_prescale = r_prescale;
  assign o_irq      = r_expired & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Data-memory port splitter: SRAM below MMIO_BASE, 16-word peripheral window
// above. Define MMIO_CYCLE_CNT_EN to build the free-running cycle counter.
module dmem_mmio_bridge
  import dsd_mmio_pkg::*;
#(
  parameter logic [15:0] MMIO_BASE  = 16'hFF00,
  parameter int          PRESCALE_W = 16,
  parameter int          LED_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [15:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic             cpu_wr,
  output logic [31:0]      cpu_rdata,
  output logic [15:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  output logic             ram_wr,
  input  logic [31:0]      ram_rdata,
  output logic [LED_W-1:0] led_out,
  output logic             irq
);

  logic                  w_sel_mmio;
  logic [3:0]            w_ofs;
  logic                  w_wr_mmio;
  logic [31:0]           w_mmio_rdata;
  logic [31:0]           w_tmr_load;
  logic [31:0]           w_tmr_count;
  logic [2:0]            w_tmr_ctrl;
  logic                  w_tmr_expired;
  logic [PRESCALE_W-1:0] w_tmr_prescale;
  logic [LED_W-1:0]      r_led;

  assign w_sel_mmio = (cpu_addr[15:4] == MMIO_BASE[15:4]);
  assign w_ofs      = cpu_addr[3:0];
  assign w_wr_mmio  = cpu_wr & w_sel_mmio;

  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_wr    = cpu_wr & ~w_sel_mmio;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)                              r_led <= '0;
    else if (w_wr_mmio && w_ofs == OFS_LED)  r_led <= cpu_wdata[LED_W-1:0];
  end

`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] r_cycle;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end
`endif

  mmio_timer #(
    .PRESCALE_W(PRESCALE_W)
  ) u_timer (
    .i_clk      (clk),
    .i_rst      (resetn),
    .i_wr_load  (w_wr_mmio && (w_ofs == OFS_TMR_LOAD)),
    .i_wr_ctrl  (w_wr_mmio && (w_ofs == OFS_TMR_CTRL)),
    .i_wr_stat  (w_wr_mmio && (w_ofs == OFS_TMR_STAT)),
    .i_wr_pre   (w_wr_mmio && (w_ofs == OFS_PRESCALE)),
    .i_wdata    (cpu_wdata),
    .o_load     (w_tmr_load),
    .o_count    (w_tmr_count),
    .o_ctrl     (w_tmr_ctrl),
    .o_expired  (w_tmr_expired),
    .o_prescale (w_tmr_prescale),
    .o_irq      (irq)
  );

  // Peripheral read mux is forced to zero while reset is asserted.
  always_comb begin
    w_mmio_rdata = '0;
    if (!resetn) begin
      case (w_ofs)
        OFS_LED:       w_mmio_rdata[LED_W-1:0] = r_led;
`ifdef MMIO_CYCLE_CNT_EN
        OFS_CYCLE:     w_mmio_rdata = r_cycle;
`endif
        OFS_TMR_LOAD:  w_mmio_rdata = w_tmr_load;
        OFS_TMR_COUNT: w_mmio_rdata = w_tmr_count;
        OFS_TMR_CTRL:  w_mmio_rdata[2:0] = w_tmr_ctrl;
        OFS_TMR_STAT:  w_mmio_rdata[0] = w_tmr_expired;
        OFS_PRESCALE:  w_mmio_rdata[PRESCALE_W-1:0] = w_tmr_prescale;
        default:       w_mmio_rdata = '0;
      endcase
    end
  end

  assign cpu_rdata = w_sel_mmio ? w_mmio_rdata : ram_rdata;
  assign led_out   = r_led;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed self-checking bench for dmem_mmio_bridge: decode, timer modes,
// W1C race, asynchronous reset and the optional cycle counter.
module tb_dmem_mmio_bridge;

  logic        clk;
  logic        resetn;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_wr;
  logic [31:0] cpu_rdata;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wr;
  logic [31:0] ram_rdata;
  logic [15:0] led_out;
  logic        irq;

  int vectors;
  int miscompares;
  logic lastRamWr;
  logic [31:0] rd;
  logic [31:0] cyc0;

  localparam logic [15:0] A_LED   = 16'hFF00;
  localparam logic [15:0] A_CYCLE = 16'hFF01;
  localparam logic [15:0] A_LOAD  = 16'hFF02;
  localparam logic [15:0] A_COUNT = 16'hFF03;
  localparam logic [15:0] A_CTRL  = 16'hFF04;
  localparam logic [15:0] A_STAT  = 16'hFF05;
  localparam logic [15:0] A_PRE   = 16'hFF06;
  localparam logic [15:0] A_UNL   = 16'hFF0A;

  dmem_mmio_bridge dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wr    (cpu_wr),
    .cpu_rdata (cpu_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wr    (ram_wr),
    .ram_rdata (ram_rdata),
    .led_out   (led_out),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One store: called just after a negedge, the write lands on the next posedge.
  task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] data);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_wr    = 1'b1;
    #1;
    lastRamWr = ram_wr;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic readReg(input logic [15:0] addr, output logic [31:0] data);
    cpu_wr   = 1'b0;
    cpu_addr = addr;
    #1;
    data = cpu_rdata;
  endtask

  task automatic checkReg(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    readReg(addr, v);
    checkOutput(tag, v, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b1;
    cpu_addr    = 16'h0000;
    cpu_wdata   = 32'h0;
    cpu_wr      = 1'b0;
    ram_rdata   = 32'hCAFE_0001;
    lastRamWr   = 1'b0;
    #12;
    checkOutput("reset_led", {16'h0, led_out}, 32'h0);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);
    resetn = 1'b0;
    @(negedge clk);
    checkReg("reset_count", A_COUNT, 32'h0);
    checkReg("reset_ctrl", A_CTRL, 32'h0);

    // Decode
    applyStimulus(16'h0010, 32'h0000_1234);
    checkOutput("ram_wr_ram_store", {31'h0, lastRamWr}, 32'h1);
    applyStimulus(A_LED, 32'h0000_00A5);
    checkOutput("ram_wr_mmio_store", {31'h0, lastRamWr}, 32'h0);
    checkOutput("led_out", {16'h0, led_out}, 32'h0000_00A5);
    checkReg("led_readback", A_LED, 32'h0000_00A5);
    checkReg("ram_read_path", 16'h0010, 32'hCAFE_0001);
    checkOutput("ram_addr", {16'h0, ram_addr}, 32'h0000_0010);
    applyStimulus(A_UNL, 32'hFFFF_FFFF);
    checkReg("unlisted_reads0", A_UNL, 32'h0);
    applyStimulus(A_CTRL, 32'hFFFF_FFF8);
    checkReg("ctrl_upper_bits0", A_CTRL, 32'h0);
    checkReg("count_still_idle", A_COUNT, 32'h0);

    // One-shot, PRESCALE=0, IRQ_EN
    applyStimulus(A_PRE, 32'h0);
    applyStimulus(A_LOAD, 32'd3);
    applyStimulus(A_CTRL, 32'h5);
    checkReg("os_count3", A_COUNT, 32'd3);
    checkOutput("os_irq_low", {31'h0, irq}, 32'h0);
    @(negedge clk);
    checkReg("os_count2", A_COUNT, 32'd2);
    @(negedge clk);
    checkReg("os_count1", A_COUNT, 32'd1);
    @(negedge clk);
    checkReg("os_count0", A_COUNT, 32'd0);
    checkReg("os_stat_pre", A_STAT, 32'h0);
    @(negedge clk);
    checkReg("os_stat_set", A_STAT, 32'h1);
    checkOutput("os_irq_high", {31'h0, irq}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    checkReg("os_done_count_holds", A_COUNT, 32'd0);

    // W1C in the same cycle as expiry: set wins
    applyStimulus(A_CTRL, 32'h0);
    applyStimulus(A_STAT, 32'h1);
    checkReg("w1c_clear", A_STAT, 32'h0);
    applyStimulus(A_CTRL, 32'h5);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(A_STAT, 32'h1);
    checkReg("race_set_wins", A_STAT, 32'h1);
    checkOutput("race_irq", {31'h0, irq}, 32'h1);
    applyStimulus(A_STAT, 32'h0);
    checkReg("w0_no_effect", A_STAT, 32'h1);
    applyStimulus(A_STAT, 32'h1);
    checkReg("later_clear", A_STAT, 32'h0);
    checkOutput("irq_dropped", {31'h0, irq}, 32'h0);

    // Auto-reload, PRESCALE=2, IRQ_EN off
    applyStimulus(A_CTRL, 32'h0);
    applyStimulus(A_PRE, 32'd2);
    applyStimulus(A_LOAD, 32'd1);
    applyStimulus(A_CTRL, 32'h3);
    checkReg("ar_start", A_COUNT, 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkReg("ar_before_tick", A_COUNT, 32'd1);
    @(negedge clk);
    checkReg("ar_first_tick", A_COUNT, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkReg("ar_no_exp_yet", A_STAT, 32'h0);
    @(negedge clk);
    checkReg("ar_expired", A_STAT, 32'h1);
    checkReg("ar_reloaded", A_COUNT, 32'd1);
    checkOutput("ar_irq_masked", {31'h0, irq}, 32'h0);
    applyStimulus(A_STAT, 32'h1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkReg("ar_second_pre", A_STAT, 32'h0);
    @(negedge clk);
    checkReg("ar_second_exp", A_STAT, 32'h1);

    // LOAD restart while running, then reset mid-run
    applyStimulus(A_CTRL, 32'h0);
    applyStimulus(A_PRE, 32'd100);
    applyStimulus(A_LOAD, 32'd9);
    applyStimulus(A_CTRL, 32'h5);
    checkReg("run_count9", A_COUNT, 32'd9);
    checkOutput("run_irq_from_sticky", {31'h0, irq}, 32'h1);
    applyStimulus(A_LOAD, 32'd5);
    checkReg("load_restart", A_COUNT, 32'd5);
    #2;
    resetn = 1'b1;
    #1;
    checkOutput("rst_led", {16'h0, led_out}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    checkReg("rst_mmio_read0", A_LED, 32'h0);
    checkReg("rst_ram_read", 16'h0010, 32'hCAFE_0001);
    cpu_wr = 1'b1;
    #1;
    checkOutput("rst_ram_wr", {31'h0, ram_wr}, 32'h1);
    cpu_wr = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    checkReg("post_rst_count", A_COUNT, 32'h0);
    checkReg("post_rst_ctrl", A_CTRL, 32'h0);
    checkReg("post_rst_stat", A_STAT, 32'h0);
    checkReg("post_rst_load", A_LOAD, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkReg("post_rst_idle", A_COUNT, 32'h0);

    // Cycle counter
`ifdef MMIO_CYCLE_CNT_EN
    readReg(A_CYCLE, cyc0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    readReg(A_CYCLE, rd);
    checkOutput("cycle_delta", rd - cyc0, 32'd10);
`else
    cyc0 = 32'h0;
    readReg(A_CYCLE, rd);
    checkOutput("cycle_absent", rd, cyc0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
